// File: rtl/adder_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : adder_share_arbiter
// Description : Round-robin arbiter letting two requesters share one external
//               combinational 32-bit adder. One operation is in flight at a
//               time: IDLE -> SETTLE (ADD_LAT cycles) -> RESP (until taken).
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i[1:0]     requester i presents an operation
//   req_ready_o[1:0]     requester i's operation accepted this cycle
//   reqN_a_i/reqN_b_i    32-bit operands of requester N
//   reqN_sub_i           1 = a - b, 0 = a + b
//   resp_valid_o[1:0]    result available for requester i
//   resp_ready_i[1:0]    requester i takes the result
//   resp_sum_o/resp_cout_o/resp_ovf_o  captured result, carry-out, overflow
//   busy_o               FSM not in IDLE
//   add_a_o/add_b_o/add_cin_o  operands driven to the shared adder
//   add_sum_i/add_cout_i       combinational result of the shared adder
//------------------------------------------------------------------------------
module adder_share_arbiter #(
   parameter int ADD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [31:0] req0_a_i,
   input  logic [31:0] req0_b_i,
   input  logic [31:0] req1_a_i,
   input  logic [31:0] req1_b_i,
   input  logic        req0_sub_i,
   input  logic        req1_sub_i,
   output logic [1:0]  resp_valid_o,
   input  logic [1:0]  resp_ready_i,
   output logic [31:0] resp_sum_o,
   output logic        resp_cout_o,
   output logic        resp_ovf_o,
   output logic        busy_o,
   output logic [31:0] add_a_o,
   output logic [31:0] add_b_o,
   output logic        add_cin_o,
   input  logic [31:0] add_sum_i,
   input  logic        add_cout_i
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   localparam logic [3:0] LAT    = 4'(ADD_LAT);

   logic [1:0]  state_q, state_d;
   logic        ptr_q, ptr_d;          // 1 = requester 1 wins a tie
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        sub_q, sub_d, id_q, id_d;
   logic [1:0]  resp_valid_q, resp_valid_d;
   logic [31:0] sum_q, sum_d;
   logic        cout_q, cout_d, ovf_q, ovf_d;
   logic [1:0]  grant;

   // A lone valid requester always wins; on a tie the pointer decides.
   assign grant[0] = req_valid_i[0] & (~req_valid_i[1] | ~ptr_q);
   assign grant[1] = req_valid_i[1] & (~req_valid_i[0] |  ptr_q);

   assign req_ready_o  = (state_q == IDLE) ? grant : 2'b00;
   assign busy_o       = (state_q != IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_sum_o   = sum_q;
   assign resp_cout_o  = cout_q;
   assign resp_ovf_o   = ovf_q;

   // Subtraction is a + ~b + 1, so the adder inputs derive purely from the
   // latched operation and stay stable until the next acceptance.
   assign add_a_o   = a_q;
   assign add_b_o   = sub_q ? ~b_q : b_q;
   assign add_cin_o = sub_q;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      sub_d        = sub_q;
      id_d         = id_q;
      resp_valid_d = resp_valid_q;
      sum_d        = sum_q;
      cout_d       = cout_q;
      ovf_d        = ovf_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               id_d    = grant[1];
               a_d     = grant[1] ? req1_a_i   : req0_a_i;
               b_d     = grant[1] ? req1_b_i   : req0_b_i;
               sub_d   = grant[1] ? req1_sub_i : req0_sub_i;
               ptr_d   = ~grant[1];
               cnt_d   = LAT;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd1) begin
               sum_d        = add_sum_i;
               cout_d       = add_cout_i;
               ovf_d        = (add_a_o[31] == add_b_o[31]) &&
                              (add_sum_i[31] != add_a_o[31]);
               resp_valid_d = id_q ? 2'b10 : 2'b01;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            // Only the owner's resp_ready completes the handshake.
            if (resp_ready_i[id_q]) begin
               resp_valid_d = 2'b00;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         cnt_q        <= 4'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         sub_q        <= 1'b0;
         id_q         <= 1'b0;
         resp_valid_q <= 2'b00;
         sum_q        <= 32'd0;
         cout_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sub_q        <= sub_d;
         id_q         <= id_d;
         resp_valid_q <= resp_valid_d;
         sum_q        <= sum_d;
         cout_q       <= cout_d;
         ovf_q        <= ovf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_adder_share_arbiter
// Description : Directed self-checking bench. u1 runs with ADD_LAT=1, u4 with
//               ADD_LAT=4; both share stimulus and each has its own adder model.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_adder_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_sub = 1'b0, req1_sub = 1'b0;
   logic [1:0]  resp_ready = 2'b00;

   logic [1:0]  u1_req_ready, u1_resp_valid, u4_req_ready, u4_resp_valid;
   logic [31:0] u1_sum, u1_add_a, u1_add_b, u1_add_sum;
   logic [31:0] u4_sum, u4_add_a, u4_add_b, u4_add_sum;
   logic        u1_cout, u1_ovf, u1_busy, u1_add_cin, u1_add_cout;
   logic        u4_cout, u4_ovf, u4_busy, u4_add_cin, u4_add_cout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // External shared adders
   assign {u1_add_cout, u1_add_sum} = {1'b0, u1_add_a} + {1'b0, u1_add_b} + {32'd0, u1_add_cin};
   assign {u4_add_cout, u4_add_sum} = {1'b0, u4_add_a} + {1'b0, u4_add_b} + {32'd0, u4_add_cin};

   adder_share_arbiter #(.ADD_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(u1_req_ready),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
      .req0_sub_i(req0_sub), .req1_sub_i(req1_sub),
      .resp_valid_o(u1_resp_valid), .resp_ready_i(resp_ready),
      .resp_sum_o(u1_sum), .resp_cout_o(u1_cout), .resp_ovf_o(u1_ovf),
      .busy_o(u1_busy),
      .add_a_o(u1_add_a), .add_b_o(u1_add_b), .add_cin_o(u1_add_cin),
      .add_sum_i(u1_add_sum), .add_cout_i(u1_add_cout)
   );

   adder_share_arbiter #(.ADD_LAT(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(u4_req_ready),
      .req0_a_i(req0_a), .req0_b_i(req0_b), .req1_a_i(req1_a), .req1_b_i(req1_b),
      .req0_sub_i(req0_sub), .req1_sub_i(req1_sub),
      .resp_valid_o(u4_resp_valid), .resp_ready_i(resp_ready),
      .resp_sum_o(u4_sum), .resp_cout_o(u4_cout), .resp_ovf_o(u4_ovf),
      .busy_o(u4_busy),
      .add_a_o(u4_add_a), .add_b_o(u4_add_b), .add_cin_o(u4_add_cin),
      .add_sum_i(u4_add_sum), .add_cout_i(u4_add_cout)
   );

   task automatic apply_reset;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if ({u1_req_ready, u1_resp_valid, u1_sum, u1_cout, u1_ovf, u1_busy, u1_add_a, u1_add_b, u1_add_cin} !== 104'd0) begin
         bad++;
         $display("FAIL reset_u1: got busy=%b rv=%b sum=%h a=%h b=%h cin=%b, want all zero",
                  u1_busy, u1_resp_valid, u1_sum, u1_add_a, u1_add_b, u1_add_cin);
      end
      total++;
      if ({u4_req_ready, u4_resp_valid, u4_sum, u4_cout, u4_ovf, u4_busy, u4_add_a, u4_add_b, u4_add_cin} !== 104'd0) begin
         bad++;
         $display("FAIL reset_u4: got busy=%b rv=%b sum=%h, want all zero", u4_busy, u4_resp_valid, u4_sum);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One complete operation on u1 (ADD_LAT=1); called at posedge+1 with u1 idle.
   task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] es, input logic ec, input logic eo, input string nm);
      logic [1:0] oh;
      oh = (id == 1) ? 2'b10 : 2'b01;
      if (id == 1) begin req1_a = a; req1_b = b; req1_sub = sub; end
      else         begin req0_a = a; req0_b = b; req0_sub = sub; end
      req_valid = oh;
      #1;
      total++;
      if (u1_req_ready !== oh) begin
         bad++; $display("FAIL %s_ready: got %b want %b", nm, u1_req_ready, oh);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      total++;
      if ({u1_busy, u1_resp_valid, u1_req_ready} !== 5'b1_00_00) begin
         bad++; $display("FAIL %s_settle: got busy=%b rv=%b rdy=%b want 1/00/00", nm, u1_busy, u1_resp_valid, u1_req_ready);
      end
      @(posedge clk); #1;
      total++;
      if (u1_resp_valid !== oh) begin
         bad++; $display("FAIL %s_resp_valid: got %b want %b", nm, u1_resp_valid, oh);
      end
      total++;
      if ({u1_sum, u1_cout, u1_ovf} !== {es, ec, eo}) begin
         bad++; $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         nm, u1_sum, u1_cout, u1_ovf, es, ec, eo);
      end
      // Non-owner resp_ready must not complete the handshake.
      resp_ready = ~oh;
      @(posedge clk); #1;
      total++;
      if ({u1_busy, u1_resp_valid} !== {1'b1, oh}) begin
         bad++; $display("FAIL %s_nonowner: got busy=%b rv=%b want 1/%b", nm, u1_busy, u1_resp_valid, oh);
      end
      resp_ready = oh;
      @(posedge clk); #1;
      resp_ready = 2'b00;
      total++;
      if ({u1_busy, u1_resp_valid} !== 3'b0_00) begin
         bad++; $display("FAIL %s_release: got busy=%b rv=%b want 0/00", nm, u1_busy, u1_resp_valid);
      end
   endtask

   task automatic test_add;
      do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "add_5_3");
      do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
      do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
   endtask

   task automatic test_sub;
      do_op(1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
      do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
   endtask

   task automatic test_round_robin;
      logic [1:0] want;
      logic       got;
      apply_reset;
      req0_a = 32'd1;  req0_b = 32'd2; req0_sub = 1'b0;   // 3
      req1_a = 32'd10; req1_b = 32'd4; req1_sub = 1'b1;   // 6
      req_valid = 2'b11;
      #1;
      for (int op = 0; op < 4; op++) begin
         want = (op % 2 == 1) ? 2'b10 : 2'b01;
         got  = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            if (u1_req_ready != 2'b00) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         total++;
         if (!got || u1_req_ready !== want) begin
            bad++; $display("FAIL rr_grant%0d: got %b want %b", op, u1_req_ready, want);
         end
         @(posedge clk); #1;
         for (int c = 0; c < 20 && u1_resp_valid == 2'b00; c++) begin
            total++;
            if (u1_req_ready !== 2'b00) begin
               bad++; $display("FAIL rr_busy_grant%0d: got %b want 00", op, u1_req_ready);
            end
            @(posedge clk); #1;
         end
         total++;
         if (u1_resp_valid !== want || u1_sum !== ((op % 2 == 1) ? 32'd6 : 32'd3)) begin
            bad++; $display("FAIL rr_resp%0d: got rv=%b sum=%h want rv=%b", op, u1_resp_valid, u1_sum, want);
         end
         total++;
         if (u1_req_ready !== 2'b00) begin
            bad++; $display("FAIL rr_resp_ready%0d: got %b want 00", op, u1_req_ready);
         end
         resp_ready = want;
         @(posedge clk); #1;
         resp_ready = 2'b00;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_mid;
      apply_reset;
      req0_a = 32'd7; req0_b = 32'd9; req0_sub = 1'b0;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      total++;
      if (u1_busy !== 1'b1) begin
         bad++; $display("FAIL mid_busy: got %b want 1", u1_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({u1_req_ready, u1_resp_valid, u1_sum, u1_cout, u1_ovf, u1_busy, u1_add_a, u1_add_b, u1_add_cin} !== 104'd0) begin
         bad++; $display("FAIL mid_reset_outputs: got busy=%b rv=%b a=%h b=%h want all zero",
                         u1_busy, u1_resp_valid, u1_add_a, u1_add_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         total++;
         if ({u1_resp_valid, u4_resp_valid} !== 4'b0000) begin
            bad++; $display("FAIL mid_no_resp%0d: got u1=%b u4=%b want 00", c, u1_resp_valid, u4_resp_valid);
         end
         @(posedge clk); #1;
      end
      req_valid = 2'b11;
      #1;
      total++;
      if ({u1_req_ready, u4_req_ready} !== 4'b0101) begin
         bad++; $display("FAIL mid_next_grant: got u1=%b u4=%b want 01", u1_req_ready, u4_req_ready);
      end
      req_valid = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_latency;
      apply_reset;
      req0_a = 32'd5; req0_b = 32'd3; req0_sub = 1'b0;
      req_valid = 2'b01;
      #1;
      total++;
      if (u4_req_ready !== 2'b01) begin
         bad++; $display("FAIL lat_ready: got %b want 01", u4_req_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         total++;
         if (u4_resp_valid !== ((c == 4) ? 2'b01 : 2'b00) || u4_add_a !== 32'd5 || u4_add_b !== 32'd3) begin
            bad++; $display("FAIL lat_cycle%0d: got rv=%b a=%h b=%h", c, u4_resp_valid, u4_add_a, u4_add_b);
         end
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         total++;
         if ({u4_resp_valid, u4_sum, u4_cout, u4_ovf, u4_busy} !== {2'b01, 32'd8, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL lat_hold%0d: got rv=%b sum=%h busy=%b want 01/8/1", c, u4_resp_valid, u4_sum, u4_busy);
         end
      end
      resp_ready = 2'b01;
      @(posedge clk); #1;
      resp_ready = 2'b00;
      total++;
      if ({u4_busy, u4_resp_valid} !== 3'b0_00) begin
         bad++; $display("FAIL lat_release: got busy=%b rv=%b want 0/00", u4_busy, u4_resp_valid);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_round_robin;
      test_reset_mid;
      test_latency;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
